mod_counter: RTL and testbench

Parametrised modulo-N event counter, the generalised successor of the fixed seconds stage in the clock datapath. Counts up or down on single-cycle event strobes and wraps at a configurable modulus. Emits registered carry/borrow pulses, so instances chain directly: seconds feed minutes, minutes feed hours. Supports synchronous preset for time setting and an optional registered BCD view for display drivers.

---
 rtl/mod_counter_pkg.sv | 26 ++
 rtl/bin2bcd8.sv | 22 ++
 rtl/mod_counter.sv | 118 +++++++++++
 tb/tb_mod_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo-N event counter.
// Holds the command decode used by mod_counter.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_LOAD
  } cnt_op_e;

  localparam int BCD_W = 8;

  // Priority: load > single strobe; both strobes together cancel to hold.
  function automatic cnt_op_e decode_op(input logic load, input logic inc, input logic dec);
    if (load)
      return OP_LOAD;
    else if (inc && !dec)
      return OP_INC;
    else if (dec && !inc)
      return OP_DEC;
    else
      return OP_HOLD;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational 0..99 binary to two-digit BCD (tens:units) via double-dabble.
// Inputs above 99 are outside the supported range.
module bin2bcd8
  import mod_counter_pkg::*;
(
  input  logic [6:0]       bin_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [14:0] scratch;

  always_comb begin
    scratch = {8'd0, bin_i};
    for (int i = 0; i < 7; i++) begin
      if (scratch[10:7] >= 4'd5) scratch[10:7] = scratch[10:7] + 4'd3;
      if (scratch[14:11] >= 4'd5) scratch[14:11] = scratch[14:11] + 4'd3;
      scratch = {scratch[13:0], 1'b0};
    end
    bcd_o = scratch[14:7];
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down event counter with registered carry/borrow/load-error pulses.
// Define MOD_COUNTER_BCD_EN to add the registered bcd_o display view.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int MODULO = 60,
  parameter int WIDTH  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o,
  output logic             borrow_o,
  output logic             load_err_o
`ifdef MOD_COUNTER_BCD_EN
  ,
  output logic [BCD_W-1:0] bcd_o
`endif
);

  if (MODULO < 2 || MODULO > 256) begin : g_chk_range
    $error("mod_counter: MODULO must be within 2..256");
  end
  if (MODULO > (1 << WIDTH)) begin : g_chk_width
    $error("mod_counter: MODULO exceeds 2**WIDTH");
  end

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0] MOD_M1  = (WIDTH + 1)'(MODULO - 1);

  cnt_op_e          op;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;

  always_comb begin
    op        = decode_op(load_i, inc_i, dec_i);
    count_ext = {1'b0, count_q};
    count_d   = count_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    err_d     = 1'b0;
    case (op)
      OP_LOAD: begin
        if ({1'b0, load_val_i} < MOD_EXT) begin
          count_d = load_val_i;
        end else begin
          count_d = MOD_M1[WIDTH-1:0];
          err_d   = 1'b1;
        end
      end
      OP_INC: begin
        if (count_ext == MOD_M1) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = WIDTH'(count_ext + 1'b1);
        end
      end
      OP_DEC: begin
        if (count_ext == '0) begin
          count_d  = MOD_M1[WIDTH-1:0];
          borrow_d = 1'b1;
        end else begin
          count_d = WIDTH'(count_ext - 1'b1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign count_o    = count_q;
  assign carry_o    = carry_q;
  assign borrow_o   = borrow_q;
  assign load_err_o = err_q;

`ifdef MOD_COUNTER_BCD_EN
  if (MODULO > 100) begin : g_chk_bcd
    $error("mod_counter: BCD view requires MODULO <= 100");
  end

  logic [BCD_W-1:0] bcd_d, bcd_q;

  // Converted from the next count so the BCD view updates on the same edge.
  bin2bcd8 u_bin2bcd8 (
    .bin_i(7'(count_d)),
    .bcd_o(bcd_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign bcd_o = bcd_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed plan, randomized commands
// against an arithmetic model, and a seconds/minutes/hours chain.
module tb_mod_counter;

  localparam int M = 60;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, inc_i, dec_i, load_i;
  logic [5:0] load_val_i;
  logic [5:0] count_o;
  logic       carry_o, borrow_o, load_err_o;

  logic       sec_inc, zero1;
  logic [5:0] zero6, sec_cnt, min_cnt;
  logic [4:0] zero5, hr_cnt;
  logic       sec_carry, sec_borrow, sec_err;
  logic       min_carry, min_borrow, min_err;
  logic       hr_carry, hr_borrow, hr_err;

`ifdef MOD_COUNTER_BCD_EN
  logic [7:0] bcd_o, sec_bcd, min_bcd, hr_bcd;
`endif

  mod_counter #(.MODULO(60), .WIDTH(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_i), .dec_i(dec_i),
    .load_i(load_i), .load_val_i(load_val_i), .count_o(count_o),
    .carry_o(carry_o), .borrow_o(borrow_o), .load_err_o(load_err_o)
`ifdef MOD_COUNTER_BCD_EN
    , .bcd_o(bcd_o)
`endif
  );

  mod_counter #(.MODULO(60), .WIDTH(6)) u_sec (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(sec_inc), .dec_i(zero1),
    .load_i(zero1), .load_val_i(zero6), .count_o(sec_cnt),
    .carry_o(sec_carry), .borrow_o(sec_borrow), .load_err_o(sec_err)
`ifdef MOD_COUNTER_BCD_EN
    , .bcd_o(sec_bcd)
`endif
  );

  mod_counter #(.MODULO(60), .WIDTH(6)) u_min (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(sec_carry), .dec_i(zero1),
    .load_i(zero1), .load_val_i(zero6), .count_o(min_cnt),
    .carry_o(min_carry), .borrow_o(min_borrow), .load_err_o(min_err)
`ifdef MOD_COUNTER_BCD_EN
    , .bcd_o(min_bcd)
`endif
  );

  mod_counter #(.MODULO(24), .WIDTH(5)) u_hr (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(min_carry), .dec_i(zero1),
    .load_i(zero1), .load_val_i(zero5), .count_o(hr_cnt),
    .carry_o(hr_carry), .borrow_o(hr_borrow), .load_err_o(hr_err)
`ifdef MOD_COUNTER_BCD_EN
    , .bcd_o(hr_bcd)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse tally for the chain, sampled mid-cycle.
  logic cnt_clr;
  int   n_sec_carry, n_min_carry;
  always @(negedge clk_i) begin
    if (cnt_clr) begin
      n_sec_carry = 0;
      n_min_carry = 0;
    end else begin
      if (sec_carry) n_sec_carry++;
      if (min_carry) n_min_carry++;
    end
  end

  // Reference model state.
  int m_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic up, input logic dn,
                      input int val, input string tag);
    int e_carry, e_borrow, e_err, nxt;
    @(negedge clk_i);
    rst_i = r; load_i = ld; inc_i = up; dec_i = dn; load_val_i = 6'(val);
    e_carry = 0; e_borrow = 0; e_err = 0;
    if (r) begin
      m_cnt = 0;
    end else if (ld) begin
      if (val < M) m_cnt = val;
      else begin m_cnt = M - 1; e_err = 1; end
    end else if (up && !dn) begin
      nxt = m_cnt + 1;
      e_carry = (nxt >= M) ? 1 : 0;
      m_cnt = nxt % M;
    end else if (dn && !up) begin
      nxt = m_cnt - 1;
      e_borrow = (nxt < 0) ? 1 : 0;
      m_cnt = (nxt + M) % M;
    end
    @(posedge clk_i);
    #1;
    chk({tag, ".count"}, int'(count_o), m_cnt);
    chk({tag, ".carry"}, int'(carry_o), e_carry);
    chk({tag, ".borrow"}, int'(borrow_o), e_borrow);
    chk({tag, ".load_err"}, int'(load_err_o), e_err);
`ifdef MOD_COUNTER_BCD_EN
    chk({tag, ".bcd"}, int'(bcd_o), (m_cnt / 10) * 16 + (m_cnt % 10));
`endif
  endtask

  initial begin
    rst_i = 1'b1; inc_i = 1'b0; dec_i = 1'b0; load_i = 1'b0; load_val_i = '0;
    sec_inc = 1'b0; zero1 = 1'b0; zero6 = '0; zero5 = '0; cnt_clr = 1'b1;

    step(1, 1, 1, 0, 33, "reset");
    step(0, 1, 0, 0, 58, "load58");
    step(0, 0, 1, 0, 0, "inc_to_59");
    step(0, 0, 1, 0, 0, "wrap_up");
    step(0, 0, 1, 0, 0, "after_wrap");
    step(0, 1, 0, 0, 0, "load0");
    step(0, 0, 0, 1, 0, "wrap_down");
    step(0, 0, 1, 1, 0, "inc_dec_cancel");
    step(0, 0, 0, 0, 0, "hold");
    step(0, 1, 0, 0, 42, "load42");
    step(0, 1, 0, 0, 63, "load63");
    step(0, 1, 1, 0, 10, "load_over_wrap");
    step(0, 1, 0, 0, 0, "load0_b");
    step(0, 1, 0, 1, 20, "load_over_borrow");
    step(0, 1, 0, 0, 60, "load60");
    step(0, 0, 1, 0, 0, "wrap_after_err");
    step(0, 1, 0, 0, 59, "load59");
    step(1, 0, 1, 0, 0, "reset_on_wrap");
    chk("reset_on_wrap.const", int'(count_o), 0);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 63)), "rand");
    end

    // Chain: 3600 second events ripple into minutes and hours.
    step(1, 0, 0, 0, 0, "chain_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    cnt_clr = 1'b0;
    for (int i = 0; i < 3600; i++) begin
      @(negedge clk_i);
      sec_inc = 1'b1;
    end
    @(negedge clk_i);
    sec_inc = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("chain.sec", int'(sec_cnt), 3600 % 60);
    chk("chain.min", int'(min_cnt), (3600 / 60) % 60);
    chk("chain.hr", int'(hr_cnt), (3600 / 3600) % 24);
    chk("chain.sec_carries", n_sec_carry, 3600 / 60);
    chk("chain.min_carries", n_min_carry, 3600 / 3600);
    chk("chain.pulses_idle", int'({sec_borrow, sec_err, min_borrow, min_err, hr_carry, hr_borrow, hr_err}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
